// File: rtl/whirlpool_mat_matrix2vector_packer_if.sv
// Row-beat input and vector output bundle for the Whirlpool matrix-to-vector packer.
// C0..C7 carry one matrix row, column 0 first. A is the packed 512-bit string
// with bit 0 as the leftmost bit.
interface whirlpool_mat_matrix2vector_packer_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [7:0]   C0;
  logic [7:0]   C1;
  logic [7:0]   C2;
  logic [7:0]   C3;
  logic [7:0]   C4;
  logic [7:0]   C5;
  logic [7:0]   C6;
  logic [7:0]   C7;
  logic         out_valid;
  logic         out_ready;
  logic [0:511] A;
  logic [2:0]   row_cnt;
  logic         frame_err;

  // The packer itself: it consumes rows and produces vectors.
  modport slave (
    input  in_valid, in_last, C0, C1, C2, C3, C4, C5, C6, C7, out_ready,
    output in_ready, out_valid, A, row_cnt, frame_err
  );

  // The surrounding logic: it sources rows and sinks vectors.
  modport master (
    output in_valid, in_last, C0, C1, C2, C3, C4, C5, C6, C7, out_ready,
    input  in_ready, out_valid, A, row_cnt, frame_err
  );
endinterface

// File: rtl/whirlpool_mat_matrix2vector_packer.sv
// Collects eight row beats of a Whirlpool 8x8 byte state and emits them as one
// 512-bit left-to-right string. Rows 0..6 are staged in asm_q. The row 7 beat
// moves asm_q plus that last row into the output register in a single step.
// This lets the next matrix be assembled while the previous vector waits for
// the consumer.
module whirlpool_mat_matrix2vector_packer #(
  parameter bit STRICT_LAST = 1'b1
) (
  input logic clk,
  input logic rst,
  whirlpool_mat_matrix2vector_packer_if.slave bus
);

  logic [0:447] asm_q;
  logic [0:511] out_q;
  logic         out_valid_q;
  logic [2:0]   row_cnt_q;
  logic         frame_err_q;

  logic [0:63]  row;
  logic         last_row;
  logic         accept;
  logic         drain;

  assign row      = {bus.C0, bus.C1, bus.C2, bus.C3, bus.C4, bus.C5, bus.C6, bus.C7};
  assign last_row = (row_cnt_q == 3'd7);

  // Only the row 7 beat needs space in out_q. Earlier rows always go into
  // asm_q, so only that beat waits on the consumer.
  assign bus.in_ready = !rst && (!last_row || !out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = out_valid_q && bus.out_ready;

  // Row staging and vector hand-off. A row 7 load that coincides with a drain
  // keeps out_valid set, because the new vector replaces the one being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      row_cnt_q   <= 3'd0;
    end else begin
      if (accept) begin
        row_cnt_q <= row_cnt_q + 3'd1;
        if (last_row) begin
          out_q <= {asm_q, row};
        end else begin
          asm_q[{row_cnt_q, 6'd0} +: 64] <= row;
        end
      end
      if (accept && last_row) begin
        out_valid_q <= 1'b1;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  generate
    if (STRICT_LAST) begin : g_strict
      // Sticky record of in_last disagreeing with the row counter. The counter
      // stays in charge, so data flow is unaffected.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          frame_err_q <= 1'b0;
        end else if (accept && (bus.in_last != last_row)) begin
          frame_err_q <= 1'b1;
        end
      end
    end else begin : g_loose
      assign frame_err_q = 1'b0;
    end
  endgenerate

  assign bus.A         = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.row_cnt   = row_cnt_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_whirlpool_mat_matrix2vector_packer.sv
// Bench for the matrix-to-vector packer. A strict and a loose instance see the
// same stimulus. A scoreboard queues each vector when its eighth row is sent and
// compares it when the strict instance hands it off.
module tb_whirlpool_mat_matrix2vector_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  whirlpool_mat_matrix2vector_packer_if bus1 ();
  whirlpool_mat_matrix2vector_packer_if bus0 ();

  whirlpool_mat_matrix2vector_packer #(.STRICT_LAST(1'b1)) dut_strict (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  whirlpool_mat_matrix2vector_packer #(.STRICT_LAST(1'b0)) dut_loose (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.in_last   = bus1.in_last;
  assign bus0.C0        = bus1.C0;
  assign bus0.C1        = bus1.C1;
  assign bus0.C2        = bus1.C2;
  assign bus0.C3        = bus1.C3;
  assign bus0.C4        = bus1.C4;
  assign bus0.C5        = bus1.C5;
  assign bus0.C6        = bus1.C6;
  assign bus0.C7        = bus1.C7;
  assign bus0.out_ready = bus1.out_ready;

  int checks = 0;
  int fails  = 0;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard model state.
  logic [63:0]  mbuf [7];
  logic [2:0]   mcnt   = 3'd0;
  bit           mvalid = 1'b0;
  bit           merr   = 1'b0;
  logic [511:0] q [$];
  bit           p_acc  = 1'b0;
  bit           p_drn  = 1'b0;
  bit           p_last = 1'b0;
  logic [63:0]  p_row  = '0;
  bit           stall  = 1'b0;
  logic [511:0] prev_a = '0;
  int           drained = 0;
  int           pushed = 0;
  int           ready_low = 0;
  int           frames_sent = 0;
  bit           rand_ready = 1'b0;

  // Mid-cycle sampling: check visible state, then note what the next edge will do.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      checkOutput("out_valid", bus1.out_valid, mvalid);
      checkOutput("row_cnt", bus1.row_cnt, mcnt);
      checkOutput("in_ready", bus1.in_ready, (mcnt != 3'd7) || !mvalid || bus1.out_ready);
      checkOutput("frame_err", bus1.frame_err, merr);
      checkOutput("frame_err_loose", bus0.frame_err, 1'b0);
      if (stall) checkOutput("a_stable", bus1.A, prev_a);
      if (bus1.in_valid && !bus1.in_ready) ready_low++;
      p_acc  = bus1.in_valid && bus1.in_ready;
      p_drn  = bus1.out_valid && bus1.out_ready;
      p_row  = {bus1.C0, bus1.C1, bus1.C2, bus1.C3, bus1.C4, bus1.C5, bus1.C6, bus1.C7};
      p_last = bus1.in_last;
      if (p_drn) begin
        if (q.size() == 0) begin
          checkOutput("vector_underflow", 1'b1, 1'b0);
        end else begin
          checkOutput("vector", bus1.A, q.pop_front());
          drained++;
        end
      end
      stall  = bus1.out_valid && !bus1.out_ready;
      prev_a = bus1.A;
    end
  end

  // Advance the model at each edge, or clear it on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt   = 3'd0;
      mvalid = 1'b0;
      merr   = 1'b0;
      q.delete();
      p_acc  = 1'b0;
      p_drn  = 1'b0;
      stall  = 1'b0;
    end else begin
      if (p_acc) begin
        if (p_last != (mcnt == 3'd7)) merr = 1'b1;
        if (mcnt == 3'd7) begin
          q.push_back({mbuf[0], mbuf[1], mbuf[2], mbuf[3], mbuf[4], mbuf[5], mbuf[6], p_row});
          pushed++;
        end else begin
          mbuf[mcnt] = p_row;
        end
      end
      if (p_acc && mcnt == 3'd7) mvalid = 1'b1;
      else if (p_drn) mvalid = 1'b0;
      if (p_acc) mcnt = mcnt + 3'd1;
      p_acc = 1'b0;
      p_drn = 1'b0;
    end
  end

  // Random consumer backpressure.
  always @(negedge clk) begin
    if (rand_ready) bus1.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic setRow(input logic [63:0] row, input bit last);
    bus1.C0 = row[63:56];
    bus1.C1 = row[55:48];
    bus1.C2 = row[47:40];
    bus1.C3 = row[39:32];
    bus1.C4 = row[31:24];
    bus1.C5 = row[23:16];
    bus1.C6 = row[15:8];
    bus1.C7 = row[7:0];
    bus1.in_last = last;
  endtask

  // Presents one row beat after an optional idle gap and holds it until it is taken.
  task automatic applyStimulus(input logic [63:0] row, input bit last, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      bus1.in_valid = 1'b0;
    end
    @(negedge clk);
    bus1.in_valid = 1'b1;
    setRow(row, last);
    #1;
    n = 0;
    while (!bus1.in_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 2000) checkOutput("accept_timeout", 1'b1, 1'b0);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus1.in_valid = 1'b0;
    end
  endtask

  // Sends eight rows of v. Bit r of last_mask drives in_last on row r.
  task automatic sendFrame(input logic [511:0] v, input int maxgap, input logic [7:0] last_mask);
    for (int r = 0; r < 8; r++) begin
      applyStimulus(v[511 - 64*r -: 64], last_mask[r], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    frames_sent++;
  endtask

  function automatic logic [511:0] fillVec(input logic [7:0] b);
    logic [511:0] v;
    for (int k = 0; k < 64; k++) v[511 - 8*k -: 8] = b;
    return v;
  endfunction

  function automatic logic [511:0] randVec();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[511 - 32*k -: 32] = $urandom;
    return v;
  endfunction

  logic [511:0] v_inc;
  logic [511:0] v_tmp;

  initial begin
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    setRow(64'd0, 1'b0);

    // Held in reset.
    #12;
    checkOutput("rst_row_cnt", bus1.row_cnt, 3'd0);
    checkOutput("rst_out_valid", bus1.out_valid, 1'b0);
    checkOutput("rst_a", bus1.A, 512'd0);
    checkOutput("rst_in_ready", bus1.in_ready, 1'b0);
    checkOutput("rst_frame_err", bus1.frame_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", bus1.in_ready, 1'b1);

    // Single frame with counting bytes.
    for (int k = 0; k < 64; k++) v_inc[511 - 8*k -: 8] = 8'(k);
    bus1.out_ready = 1'b1;
    sendFrame(v_inc, 0, 8'h80);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #1;
    checkOutput("single_valid", bus1.out_valid, 1'b1);
    checkOutput("single_a", bus1.A, v_inc);
    checkOutput("single_row_cnt", bus1.row_cnt, 3'd0);
    @(negedge clk);
    #1;
    checkOutput("single_valid_drop", bus1.out_valid, 1'b0);
    checkOutput("single_frame_err", bus1.frame_err, 1'b0);

    // Backpressure: second frame's last row waits for the consumer.
    bus1.out_ready = 1'b0;
    sendFrame(fillVec(8'hAA), 0, 8'h80);
    for (int r = 0; r < 7; r++) applyStimulus({8{8'h55}}, 1'b0, 0);
    @(negedge clk);
    bus1.in_valid = 1'b1;
    setRow({8{8'h55}}, 1'b1);
    #1;
    checkOutput("bp_in_ready_low", bus1.in_ready, 1'b0);
    checkOutput("bp_a_hold", bus1.A, fillVec(8'hAA));
    @(negedge clk);
    #1;
    checkOutput("bp_in_ready_low2", bus1.in_ready, 1'b0);
    checkOutput("bp_a_hold2", bus1.A, fillVec(8'hAA));
    @(negedge clk);
    bus1.out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_high", bus1.in_ready, 1'b1);
    @(posedge clk);
    frames_sent++;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    #1;
    checkOutput("bp_a_new", bus1.A, fillVec(8'h55));
    checkOutput("bp_valid_kept", bus1.out_valid, 1'b1);
    @(negedge clk);
    bus1.out_ready = 1'b1;
    idle(2);

    // Four frames streamed back to back.
    ready_low = 0;
    v_tmp = {16'h0000, 496'(drained)};
    for (int f = 0; f < 4; f++) sendFrame(randVec(), 0, 8'h80);
    idle(3);
    checkOutput("stream_no_stall", ready_low, 0);
    checkOutput("stream_vectors", drained - int'(v_tmp[31:0]), 4);

    // in_last on row 3: flagged by the strict instance only, data intact.
    sendFrame(randVec(), 0, 8'h88);
    idle(2);
    checkOutput("ferr_strict", bus1.frame_err, 1'b1);
    checkOutput("ferr_loose", bus0.frame_err, 1'b0);

    // Asynchronous reset after five rows.
    for (int r = 0; r < 5; r++) applyStimulus({8{8'h77}}, 1'b0, 0);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_row_cnt", bus1.row_cnt, 3'd0);
    checkOutput("arst_out_valid", bus1.out_valid, 1'b0);
    checkOutput("arst_a", bus1.A, 512'd0);
    checkOutput("arst_in_ready", bus1.in_ready, 1'b0);
    checkOutput("arst_frame_err", bus1.frame_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sendFrame(fillVec(8'h11), 0, 8'h80);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #1;
    checkOutput("arst_new_a", bus1.A, fillVec(8'h11));
    idle(2);

    // Random gaps and backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 1000; f++) sendFrame(randVec(), 2, 8'h80);
    idle(1);
    rand_ready = 1'b0;
    @(negedge clk);
    bus1.out_ready = 1'b1;
    idle(4);
    checkOutput("queue_empty", q.size(), 0);
    checkOutput("pushed_count", pushed, frames_sent);
    checkOutput("drained_count", drained, pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Backstop against a stuck run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
